// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Backing instruction memory for the I-cache refill port. Holds MEM_WORDS
//   32-bit words and answers each word read a fixed LATENCY cycles after the
//   request is first sampled. This gives a deterministic miss penalty in
//   simulation and FPGA builds.
//
// Ports
//   clk, reset        clock (posedge) and synchronous active-high reset
//   mem_req_valid     read request, held by the cache until ready
//   mem_req_addr      byte address, bits [1:0] ignored
//   mem_req_ready     one-cycle pulse, mem_req_rdata valid in that cycle
//   mem_req_rdata     read word (0 for out-of-range addresses)
//   load_en/addr/data backdoor word write, accepted in any state
//   oob_err           sticky flag: an out-of-range address was served
//   req_count         number of completed responses, wraps at 2^32
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          LATENCY   = 2,
    parameter              INIT_FILE = "",
    localparam int         ADDR_BITS = $clog2(MEM_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_req_valid,
    input  logic [31:0]          mem_req_addr,
    output logic                 mem_req_ready,
    output logic [31:0]          mem_req_rdata,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [31:0]          load_data,
    output logic                 oob_err,
    output logic [31:0]          req_count
);

    // Counter only needs to hold LATENCY-1.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("imem_responder: LATENCY must be >= 1");
        end
    endgenerate

    logic [31:0] mem_q [MEM_WORDS];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             oob_q, oob_d;
    logic [31:0]      count_q, count_d;

    // With LATENCY==1 the response is produced on the accept edge, so the
    // live address is decoded in IDLE; otherwise the captured one is used.
    logic [31:0]          serve_addr;
    logic [32:0]          diff;
    logic                 in_range;
    logic [ADDR_BITS-1:0] idx;
    logic                 fire;
    logic                 unused_ok;

    assign serve_addr = (state_q == IDLE) ? mem_req_addr : addr_q;
    // 33-bit subtract: bit 32 is the borrow, i.e. addr < BASE_ADDR.
    assign diff       = {1'b0, serve_addr} - {1'b0, BASE_ADDR};
    assign in_range   = !diff[32] && ((diff[31:0] >> 2) < 32'(MEM_WORDS));
    assign idx        = diff[ADDR_BITS+1:2];
    assign unused_ok  = ^diff[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        oob_d   = oob_q;
        count_d = count_q;
        fire    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req_valid) begin
                    addr_d = mem_req_addr;
                    if (LATENCY == 1) begin
                        fire = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                // A dropped valid aborts silently, even on the final count.
                if (!mem_req_valid)            state_d = IDLE;
                else if (cnt_q == CNT_W'(1))   fire    = 1'b1;
                else                           cnt_d   = cnt_q - CNT_W'(1);
            end
            RESP: state_d = GAP;
            GAP:  if (!mem_req_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fire) begin
            state_d = RESP;
            ready_d = 1'b1;
            // Array read sees the pre-edge contents, so a same-edge backdoor
            // write to this word returns the old value.
            rdata_d = in_range ? mem_q[idx] : 32'h0;
            oob_d   = oob_q | !in_range;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            oob_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            oob_q   <= oob_d;
            count_q <= count_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en) mem_q[load_addr] <= load_data;
    end

    assign mem_req_ready = ready_q;
    assign mem_req_rdata = rdata_q;
    assign oob_err       = oob_q;
    assign req_count     = count_q;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//   Directed bench for imem_responder (MEM_WORDS=64, BASE_ADDR=0x100,
//   LATENCY=2). Expected read data is queued when a request is issued and
//   compared when the ready pulse appears.
// -----------------------------------------------------------------------------
module tb_imem_responder;

    localparam int          MW   = 64;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          LAT  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] addr;
    logic        rdy;
    logic [31:0] rdata;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        oob;
    logic [31:0] count;

    imem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(valid), .mem_req_addr(addr),
        .mem_req_ready(rdy), .mem_req_rdata(rdata),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .oob_err(oob), .req_count(count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_r   = 0;
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard side: every ready pulse must match the oldest queued word.
    always @(negedge clk) begin
        if (rdy === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_ready", {31'd0, rdy}, 32'd0);
            else                   chk("rdata", rdata, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load(input int i, input logic [31:0] d);
        load_en = 1'b1; load_addr = 6'(i); load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // Cache-style read: raise valid, wait for ready, drop valid the cycle
    // after, and return once the responder is back in IDLE.
    task automatic read(input logic [31:0] a, input logic [31:0] e, input bit chk_pitch);
        int  c0;
        int  rc;
        bit  seen;
        exp_q.push_back(e);
        c0 = cyc; seen = 0; rc = 0;
        valid = 1'b1; addr = a;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rdy === 1'b1) begin seen = 1; rc = cyc; end
        end
        chk("ready_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            chk("latency", 32'(rc - c0), 32'(LAT));
            if (chk_pitch) chk("pitch", 32'(rc - last_r), 32'(LAT + 2));
            last_r = rc;
        end
        tick();
        chk("pulse_width", {31'd0, rdy}, 32'd0);
        valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valid = 1'b0; addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        tick();
        load(0, 32'h11111111);
        load(1, 32'h22222222);
        load(2, 32'h33333333);
        load(3, 32'h44444444);
        chk("rst_ready", {31'd0, rdy}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_oob",   {31'd0, oob}, 32'd0);
        chk("rst_count", count, 32'd0);
        reset = 1'b0;
        tick();

        // Single read with latency 2.
        read(BASE, 32'h11111111, 0);
        chk("count_1", count, 32'd1);

        // Four-word refill at minimum pitch.
        read(BASE + 32'h0, 32'h11111111, 0);
        read(BASE + 32'h4, 32'h22222222, 1);
        read(BASE + 32'h8, 32'h33333333, 1);
        read(BASE + 32'hC, 32'h44444444, 1);
        chk("count_5", count, 32'd5);

        // Valid held for one cycle only: aborted in WAIT.
        valid = 1'b1; addr = BASE + 32'h4;
        tick();
        valid = 1'b0;
        repeat (5) tick();
        chk("abort_count", count, 32'd5);
        read(BASE + 32'h4, 32'h22222222, 0);
        chk("count_6", count, 32'd6);

        // Out of range past the top, then below the base.
        read(BASE + 32'(4 * MW), 32'h0, 0);
        chk("oob_set", {31'd0, oob}, 32'd1);
        repeat (10) tick();
        chk("oob_sticky", {31'd0, oob}, 32'd1);
        read(BASE - 32'h4, 32'h0, 0);
        chk("count_8", count, 32'd8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("oob_cleared", {31'd0, oob}, 32'd0);
        chk("count_cleared", count, 32'd0);

        // Reset in WAIT on the cycle the count would expire.
        valid = 1'b1; addr = BASE;
        tick();
        reset = 1'b1; valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("rst_wait_ready", {31'd0, rdy}, 32'd0);
        tick();
        chk("rst_wait_ready2", {31'd0, rdy}, 32'd0);
        chk("rst_wait_count", count, 32'd0);
        read(BASE, 32'h11111111, 0);

        // Address changed in WAIT is ignored; same-edge load returns old data.
        exp_q.push_back(32'h22222222);
        valid = 1'b1; addr = BASE + 32'h6;
        tick();
        addr = BASE + 32'h40;
        load_en = 1'b1; load_addr = 6'd1; load_data = 32'hDEADBEEF;
        tick();
        load_en = 1'b0;
        chk("resp_ready", {31'd0, rdy}, 32'd1);
        tick();
        valid = 1'b0;
        tick();
        read(BASE + 32'h4, 32'hDEADBEEF, 0);
        chk("count_final", count, 32'd3);

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
